rf_wb_arbiter: RTL

- Shares the single register-file write port (write_en / wr_addr / val_in) between two write-back requesters: ALU results and memory-load results.
- Each requester has its own 2-entry queue with a valid/ready handshake.
- Each cycle the block issues at most one queued write to the register file:
  - round-robin between requesters;
  - same-address ordering preserved by age tag.
- Also flags read-after-write hazards for the decode stage against writes not yet committed.

---
 rtl/rf_wb_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port between two write-back
//   requesters (ALU results and memory-load results). Each requester owns a
//   2-entry FIFO with a valid/ready handshake. At most one queued write is
//   issued per cycle. Requesters alternate round-robin, but when both heads
//   target the same register the older entry (by age tag) goes first. A
//   combinational hazard flag tells decode whether either source register
//   still has a write outstanding.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   alu_valid/ready/addr/data   ALU write-back request channel
//   ld_valid/ready/addr/data    load write-back request channel
//   rd_addr1, rd_addr2      decode source registers for hazard check
//   hazard                  a source matches a queued or in-flight write
//   rf_write_en/wr_addr/val_in  registered register-file write port
//   pending_cnt             total queued entries (0..4), registered
module rf_wb_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int Q_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_val_in,
    output logic [2:0]        pending_cnt
);
    localparam int   TAG_W   = 3;
    localparam int   NREQ    = 2;
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_LD  = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } wb_entry_t;

    // Index 0 = ALU queue, index 1 = load queue.
    wb_entry_t            q_mem  [NREQ][Q_DEPTH];
    wb_entry_t            in_ent [NREQ];
    wb_entry_t            head   [NREQ];
    logic [NREQ-1:0]      rd_ptr;
    logic [NREQ-1:0]      wr_ptr;
    logic [NREQ-1:0][1:0] occ;
    logic [NREQ-1:0][1:0] occ_next;
    logic [NREQ-1:0][1:0] ent_vld;
    logic [NREQ-1:0]      ready_q;
    logic [NREQ-1:0]      valid_in;
    logic [NREQ-1:0]      push;
    logic [NREQ-1:0]      pop;
    logic [NREQ-1:0]      nonempty;
    logic [TAG_W-1:0]     tag_cnt;
    logic [TAG_W-1:0]     tag_diff;
    logic                 alu_older;
    logic                 grant_valid;
    logic                 grant_sel;
    logic                 last_grant;

    assign alu_ready = ready_q[0];
    assign ld_ready  = ready_q[1];
    assign valid_in  = {ld_valid, alu_valid};

    // Ready is a flop of "not full", so a full queue refuses a push even
    // when it pops on the same edge.
    assign push = valid_in & ready_q;

    // On a dual accept the ALU entry takes the current tag and the load
    // entry the next one, making the ALU write the older of the pair.
    always_comb begin
        in_ent[0].addr = alu_addr;
        in_ent[0].data = alu_data;
        in_ent[0].tag  = tag_cnt;
        in_ent[1].addr = ld_addr;
        in_ent[1].data = ld_data;
        in_ent[1].tag  = tag_cnt + TAG_W'(push[0]);
    end

    // Queue heads and per-slot valid masks.
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            head[r]     = q_mem[r][rd_ptr[r]];
            nonempty[r] = (occ[r] != 2'd0);
            case (occ[r])
                2'd1:    ent_vld[r] = rd_ptr[r] ? 2'b10 : 2'b01;
                2'd2:    ent_vld[r] = 2'b11;
                default: ent_vld[r] = 2'b00;
            endcase
        end
    end

    // Issue selection. Tags are compared modulo 8: A is older than B when
    // (tagB - tagA) mod 8 lies in 1..4. With at most four entries alive the
    // live tags never span more than that window.
    always_comb begin
        tag_diff    = head[1].tag - head[0].tag;
        alu_older   = (tag_diff != '0) && (tag_diff <= TAG_W'(4));
        grant_valid = |nonempty;
        grant_sel   = SEL_ALU;
        if (nonempty[0] && nonempty[1]) begin
            if (head[0].addr == head[1].addr)
                grant_sel = alu_older ? SEL_ALU : SEL_LD;
            else
                grant_sel = ~last_grant;
        end else if (nonempty[1]) begin
            grant_sel = SEL_LD;
        end
        pop[0] = grant_valid && (grant_sel == SEL_ALU);
        pop[1] = grant_valid && (grant_sel == SEL_LD);
    end

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            occ_next[r] = occ[r];
            if (push[r] && !pop[r])
                occ_next[r] = occ[r] + 2'd1;
            else if (!push[r] && pop[r])
                occ_next[r] = occ[r] - 2'd1;
        end
    end

    // Hazard: any live queue slot or the write currently on the RF port.
    always_comb begin
        hazard = rf_write_en &&
                 ((rf_wr_addr == rd_addr1) || (rf_wr_addr == rd_addr2));
        for (int r = 0; r < NREQ; r++) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (ent_vld[r][i] &&
                    ((q_mem[r][i].addr == rd_addr1) ||
                     (q_mem[r][i].addr == rd_addr2)))
                    hazard = 1'b1;
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREQ; r++) begin
            if (push[r])
                q_mem[r][wr_ptr[r]] <= in_ent[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            ready_q     <= '1;
            tag_cnt     <= '0;
            last_grant  <= SEL_LD;   // ALU wins the first tie
            rf_write_en <= 1'b0;
            rf_wr_addr  <= '0;
            rf_val_in   <= '0;
            pending_cnt <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (push[r])
                    wr_ptr[r] <= ~wr_ptr[r];
                if (pop[r])
                    rd_ptr[r] <= ~rd_ptr[r];
                occ[r]     <= occ_next[r];
                ready_q[r] <= (occ_next[r] != 2'd2);
            end
            tag_cnt     <= tag_cnt + TAG_W'(push[0]) + TAG_W'(push[1]);
            pending_cnt <= 3'(occ_next[0]) + 3'(occ_next[1]);
            rf_write_en <= grant_valid;
            if (grant_valid) begin
                rf_wr_addr <= head[grant_sel].addr;
                rf_val_in  <= head[grant_sel].data;
                last_grant <= grant_sel;
            end
        end
    end

endmodule
